// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run-control / status block for the simple core. It sequences
//   IDLE -> BOOT -> RUN -> HALT, counts RUN cycles and retired instructions,
//   runs an optional no-retire watchdog, and reports pass/fail once halted.
//
// Parameters
//   BOOT_CYCLES  cycles spent in BOOT before RUN (0 = straight to RUN)
//   CNT_W        width of io_cycles / io_instret
//   WDOG_CYCLES  consecutive no-retire RUN cycles before forced HALT (0 = off)
//
// Ports
//   clock        in   single clock, all state on posedge
//   reset        in   synchronous, active-high
//   io_start     in   start pulse, honoured in IDLE or HALT
//   io_retire    in   one instruction retired, honoured in RUN
//   io_halt_req  in   halt request, honoured in RUN
//   io_booting   out  state == BOOT
//   io_running   out  state == RUN
//   io_done      out  state == HALT
//   io_timeout   out  HALT caused by watchdog (valid while io_done)
//   io_result    out  io_done & ~io_timeout
//   io_cycles    out  RUN-cycle count (saturating)
//   io_instret   out  retired-instruction count (saturating)
//
// Configuration
//   CORE_TRACE_EN  when defined, prints every state transition (simulation
//                  only).
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WDOG_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_retire,
  input  logic             io_halt_req,
  output logic             io_booting,
  output logic             io_running,
  output logic             io_done,
  output logic             io_timeout,
  output logic             io_result,
  output logic [CNT_W-1:0] io_cycles,
  output logic [CNT_W-1:0] io_instret
);

  // Boot counter only ever holds BOOT_CYCLES-1.
  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LOAD =
    BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

  localparam int unsigned WD_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state,    state_nxt;
  logic [BOOT_W-1:0] boot_cnt, boot_nxt;
  logic [CNT_W-1:0]  cyc_cnt,  cyc_nxt;
  logic [CNT_W-1:0]  ret_cnt,  ret_nxt;
  logic [WD_W-1:0]   wd_cnt,   wd_nxt;
  logic              timeout,  timeout_nxt;
  logic              wd_expire;

  // Expiry is the WDOG_CYCLES-th consecutive idle cycle: the count already
  // holds WDOG_CYCLES-1 and this cycle does not retire either.
  always_comb begin
    wd_expire = (WDOG_CYCLES != 0) && !io_retire && (wd_cnt == WD_LAST);
  end

  always_comb begin
    state_nxt   = state;
    boot_nxt    = boot_cnt;
    cyc_nxt     = cyc_cnt;
    ret_nxt     = ret_cnt;
    wd_nxt      = wd_cnt;
    timeout_nxt = timeout;

    case (state)
      S_IDLE, S_HALT: begin
        if (io_start) begin
          cyc_nxt     = '0;
          ret_nxt     = '0;
          wd_nxt      = '0;
          timeout_nxt = 1'b0;
          boot_nxt    = BOOT_LOAD;
          state_nxt   = (BOOT_CYCLES == 0) ? S_RUN : S_BOOT;
        end
      end

      S_BOOT: begin
        if (boot_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          boot_nxt = boot_cnt - BOOT_W'(1);
        end
      end

      S_RUN: begin
        if (cyc_cnt != '1) begin
          cyc_nxt = cyc_cnt + CNT_W'(1);
        end
        if (io_retire && (ret_cnt != '1)) begin
          ret_nxt = ret_cnt + CNT_W'(1);
        end
        if (WDOG_CYCLES != 0) begin
          if (io_retire) begin
            wd_nxt = '0;
          end else if (wd_cnt != '1) begin
            wd_nxt = wd_cnt + WD_W'(1);
          end
        end
        // Halt request takes priority over a coincident watchdog expiry.
        if (io_halt_req) begin
          state_nxt   = S_HALT;
          timeout_nxt = 1'b0;
        end else if (wd_expire) begin
          state_nxt   = S_HALT;
          timeout_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      boot_cnt <= '0;
      cyc_cnt  <= '0;
      ret_cnt  <= '0;
      wd_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_nxt;
      cyc_cnt  <= cyc_nxt;
      ret_cnt  <= ret_nxt;
      wd_cnt   <= wd_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    io_booting = (state == S_BOOT);
    io_running = (state == S_RUN);
    io_done    = (state == S_HALT);
    io_timeout = timeout;
    io_result  = (state == S_HALT) && !timeout;
    io_cycles  = cyc_cnt;
    io_instret = ret_cnt;
  end

`ifdef CORE_TRACE_EN
`ifndef SYNTHESIS
  function automatic string state_name(input state_t s);
    case (s)
      S_IDLE:  return "IDLE";
      S_BOOT:  return "BOOT";
      S_RUN:   return "RUN";
      default: return "HALT";
    endcase
  endfunction

  state_t    trace_nxt;
  logic      trace_cond;

  always_comb begin
    trace_nxt  = reset ? S_IDLE : state_nxt;
    trace_cond = 1'b1;
  end

  always @(posedge clock) begin
    if (trace_cond && (trace_nxt != state)) begin
      $display("core_run_ctrl: %s -> %s cyc=%0d ret=%0d",
               state_name(state), state_name(trace_nxt),
               reset ? '0 : cyc_nxt, reset ? '0 : ret_nxt);
      if (trace_nxt == S_HALT) begin
        $display("core_run_ctrl: %s", timeout_nxt ? "TIMEOUT" : "PASS");
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. Three instances share clock and reset:
//     u_main : BOOT_CYCLES=4, CNT_W=32, watchdog off
//     u_wd   : BOOT_CYCLES=4, CNT_W=32, WDOG_CYCLES=8
//     u_sat  : BOOT_CYCLES=0, CNT_W=4,  watchdog off
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam logic [4:0] ST_IDLE = 5'b00000;
  localparam logic [4:0] ST_BOOT = 5'b10000;
  localparam logic [4:0] ST_RUN  = 5'b01000;
  localparam logic [4:0] ST_PASS = 5'b00101;
  localparam logic [4:0] ST_TOUT = 5'b00110;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        m_start = 1'b0, m_retire = 1'b0, m_halt = 1'b0;
  logic        m_booting, m_running, m_done, m_timeout, m_result;
  logic [31:0] m_cycles, m_instret;

  logic        w_start = 1'b0, w_retire = 1'b0, w_halt = 1'b0;
  logic        w_booting, w_running, w_done, w_timeout, w_result;
  logic [31:0] w_cycles, w_instret;

  logic        s_start = 1'b0, s_retire = 1'b0, s_halt = 1'b0;
  logic        s_booting, s_running, s_done, s_timeout, s_result;
  logic [3:0]  s_cycles, s_instret;

  logic [4:0]  m_st, w_st, s_st;
  logic [68:0] m_flat, w_flat;
  logic [12:0] s_flat;

  assign m_st   = {m_booting, m_running, m_done, m_timeout, m_result};
  assign w_st   = {w_booting, w_running, w_done, w_timeout, w_result};
  assign s_st   = {s_booting, s_running, s_done, s_timeout, s_result};
  assign m_flat = {m_st, m_cycles, m_instret};
  assign w_flat = {w_st, w_cycles, w_instret};
  assign s_flat = {s_st, s_cycles, s_instret};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  core_run_ctrl #(.BOOT_CYCLES(4), .CNT_W(32), .WDOG_CYCLES(0)) u_main (
    .clock(clock), .reset(reset), .io_start(m_start), .io_retire(m_retire),
    .io_halt_req(m_halt), .io_booting(m_booting), .io_running(m_running),
    .io_done(m_done), .io_timeout(m_timeout), .io_result(m_result),
    .io_cycles(m_cycles), .io_instret(m_instret)
  );

  core_run_ctrl #(.BOOT_CYCLES(4), .CNT_W(32), .WDOG_CYCLES(8)) u_wd (
    .clock(clock), .reset(reset), .io_start(w_start), .io_retire(w_retire),
    .io_halt_req(w_halt), .io_booting(w_booting), .io_running(w_running),
    .io_done(w_done), .io_timeout(w_timeout), .io_result(w_result),
    .io_cycles(w_cycles), .io_instret(w_instret)
  );

  core_run_ctrl #(.BOOT_CYCLES(0), .CNT_W(4), .WDOG_CYCLES(0)) u_sat (
    .clock(clock), .reset(reset), .io_start(s_start), .io_retire(s_retire),
    .io_halt_req(s_halt), .io_booting(s_booting), .io_running(s_running),
    .io_done(s_done), .io_timeout(s_timeout), .io_result(s_result),
    .io_cycles(s_cycles), .io_instret(s_instret)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_start = i[0]; m_retire = ~i[0]; m_halt = 1'b1;
      w_start = i[0]; w_retire = ~i[0]; w_halt = 1'b1;
      s_start = i[0]; s_retire = ~i[0]; s_halt = 1'b1;
      tick();
      vectors++;
      if (m_flat !== '0) begin
        miscompares++; $display("FAIL reset_main: got %h expected 0", m_flat);
      end
      vectors++;
      if (w_flat !== '0) begin
        miscompares++; $display("FAIL reset_wd: got %h expected 0", w_flat);
      end
      vectors++;
      if (s_flat !== '0) begin
        miscompares++; $display("FAIL reset_sat: got %h expected 0", s_flat);
      end
    end
    reset = 1'b0;
    m_start = 1'b0; m_retire = 1'b0; m_halt = 1'b0;
    w_start = 1'b0; w_retire = 1'b0; w_halt = 1'b0;
    s_start = 1'b0; s_retire = 1'b0; s_halt = 1'b0;
    tick();
    vectors++;
    if (m_flat !== '0 || w_flat !== '0 || s_flat !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h/%h/%h expected all 0", m_flat, w_flat, s_flat);
    end
  endtask

  task automatic test_boot;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (m_st !== ST_BOOT) begin
        miscompares++; $display("FAIL boot_cycle%0d: got %b expected %b", c, m_st, ST_BOOT);
      end
      m_start = (c == 2);
      tick();
    end
    vectors++;
    if (m_st !== ST_RUN || m_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL run_entry: got st=%b cyc=%0d expected st=%b cyc=0", m_st, m_cycles, ST_RUN);
    end
  endtask

  task automatic test_run_halt;
    logic [9:0] pattern;
    pattern = 10'b1110101101;
    for (int k = 1; k <= 10; k++) begin
      m_retire = pattern[k-1];
      m_halt   = (k == 10);
      m_start  = (k == 3);
      tick();
      if (k < 10) begin
        vectors++;
        if (m_st !== ST_RUN || m_cycles !== 32'(k)) begin
          miscompares++;
          $display("FAIL run_cycle%0d: got st=%b cyc=%0d expected st=%b cyc=%0d", k, m_st, m_cycles, ST_RUN, k);
        end
      end
    end
    m_retire = 1'b0; m_halt = 1'b0; m_start = 1'b0;
    vectors++;
    if (m_st !== ST_PASS || m_cycles !== 32'd10 || m_instret !== 32'd7) begin
      miscompares++;
      $display("FAIL halt_pass: got st=%b cyc=%0d ret=%0d expected st=%b cyc=10 ret=7", m_st, m_cycles, m_instret, ST_PASS);
    end
    for (int i = 0; i < 20; i++) begin
      m_retire = i[0];
      m_halt   = i[1];
      tick();
      vectors++;
      if (m_flat !== {ST_PASS, 32'd10, 32'd7}) begin
        miscompares++;
        $display("FAIL halt_hold%0d: got st=%b cyc=%0d ret=%0d expected st=%b cyc=10 ret=7", i, m_st, m_cycles, m_instret, ST_PASS);
      end
    end
    m_retire = 1'b0; m_halt = 1'b0;
  endtask

  task automatic test_restart_from_halt;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    vectors++;
    if (m_flat !== {ST_BOOT, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL restart_clear: got st=%b cyc=%0d ret=%0d expected st=%b cyc=0 ret=0", m_st, m_cycles, m_instret, ST_BOOT);
    end
  endtask

  task automatic test_reset_mid_run;
    repeat (4) tick();
    vectors++;
    if (m_st !== ST_RUN) begin
      miscompares++; $display("FAIL midrun_enter: got %b expected %b", m_st, ST_RUN);
    end
    m_retire = 1'b1;
    repeat (5) tick();
    m_retire = 1'b0;
    vectors++;
    if (m_flat !== {ST_RUN, 32'd5, 32'd5}) begin
      miscompares++;
      $display("FAIL midrun_counts: got st=%b cyc=%0d ret=%0d expected st=%b cyc=5 ret=5", m_st, m_cycles, m_instret, ST_RUN);
    end
    reset = 1'b1; m_retire = 1'b1; m_halt = 1'b1;
    tick();
    vectors++;
    if (m_flat !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got %h expected 0", m_flat);
    end
    reset = 1'b0; m_retire = 1'b0; m_halt = 1'b0;
    tick();
    vectors++;
    if (m_flat !== '0) begin
      miscompares++; $display("FAIL midrun_idle: got %h expected 0", m_flat);
    end
  endtask

  task automatic test_watchdog;
    // Plain expiry after 8 idle RUN cycles.
    w_start = 1'b1; tick(); w_start = 1'b0;
    repeat (4) tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        vectors++;
        if (w_st !== ST_RUN || w_cycles !== 32'(k)) begin
          miscompares++;
          $display("FAIL wdog_run%0d: got st=%b cyc=%0d expected st=%b cyc=%0d", k, w_st, w_cycles, ST_RUN, k);
        end
      end
    end
    vectors++;
    if (w_flat !== {ST_TOUT, 32'd8, 32'd0}) begin
      miscompares++;
      $display("FAIL wdog_expire: got st=%b cyc=%0d ret=%0d expected st=%b cyc=8 ret=0", w_st, w_cycles, w_instret, ST_TOUT);
    end

    // Retire on the would-be expiry cycle keeps it running, count restarts.
    w_start = 1'b1; tick(); w_start = 1'b0;
    vectors++;
    if (w_flat !== {ST_BOOT, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL wdog_restart: got st=%b cyc=%0d ret=%0d expected st=%b cyc=0 ret=0", w_st, w_cycles, w_instret, ST_BOOT);
    end
    repeat (4) tick();
    for (int k = 1; k <= 8; k++) begin
      w_retire = (k == 8);
      tick();
    end
    w_retire = 1'b0;
    vectors++;
    if (w_flat !== {ST_RUN, 32'd8, 32'd1}) begin
      miscompares++;
      $display("FAIL wdog_saved: got st=%b cyc=%0d ret=%0d expected st=%b cyc=8 ret=1", w_st, w_cycles, w_instret, ST_RUN);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        vectors++;
        if (w_st !== ST_RUN) begin
          miscompares++; $display("FAIL wdog_rearm7: got %b expected %b", w_st, ST_RUN);
        end
      end
    end
    vectors++;
    if (w_flat !== {ST_TOUT, 32'd16, 32'd1}) begin
      miscompares++;
      $display("FAIL wdog_rearm_expire: got st=%b cyc=%0d ret=%0d expected st=%b cyc=16 ret=1", w_st, w_cycles, w_instret, ST_TOUT);
    end

    // Halt request coinciding with expiry wins: pass, not timeout.
    w_start = 1'b1; tick(); w_start = 1'b0;
    repeat (4) tick();
    for (int k = 1; k <= 8; k++) begin
      w_halt = (k == 8);
      tick();
    end
    w_halt = 1'b0;
    vectors++;
    if (w_flat !== {ST_PASS, 32'd8, 32'd0}) begin
      miscompares++;
      $display("FAIL wdog_halt_wins: got st=%b cyc=%0d ret=%0d expected st=%b cyc=8 ret=0", w_st, w_cycles, w_instret, ST_PASS);
    end
  endtask

  task automatic test_saturation;
    s_start = 1'b1; tick(); s_start = 1'b0;
    vectors++;
    if (s_flat !== {ST_RUN, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL sat_noboot: got st=%b cyc=%0d ret=%0d expected st=%b cyc=0 ret=0", s_st, s_cycles, s_instret, ST_RUN);
    end
    s_retire = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      s_halt = (k == 20);
      tick();
      if (k == 15 || k == 16) begin
        vectors++;
        if (s_flat !== {ST_RUN, 4'd15, 4'd15}) begin
          miscompares++;
          $display("FAIL sat_cycle%0d: got st=%b cyc=%0d ret=%0d expected st=%b cyc=15 ret=15", k, s_st, s_cycles, s_instret, ST_RUN);
        end
      end
    end
    s_retire = 1'b0; s_halt = 1'b0;
    vectors++;
    if (s_flat !== {ST_PASS, 4'd15, 4'd15}) begin
      miscompares++;
      $display("FAIL sat_halt: got st=%b cyc=%0d ret=%0d expected st=%b cyc=15 ret=15", s_st, s_cycles, s_instret, ST_PASS);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_run_halt();
    test_restart_from_halt();
    test_reset_mid_run();
    test_watchdog();
    test_saturation();
    vectors++;
    if (m_st !== ST_IDLE) begin
      miscompares++; $display("FAIL main_final_idle: got %b expected %b", m_st, ST_IDLE);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
